// File: rtl/mdu_pkg.sv
// mdu_pkg: op/state encodings and default latencies for the HI/LO
// multiply/divide unit. Shared with the decoder that produces MAD_sel.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_LAT = 5;
    localparam int MDU_DIV_LAT  = 10;
    localparam int MDU_CNT_W    = 4;

    // mult/multu/div/divu all have op[2]==0
    function automatic logic is_md_op(
        input logic [2:0] op
    );
        return ~op[2];
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result from latched op/a/b.
// Ports: i_op/i_a/i_b in; o_res {hi,lo}; o_wr=0 suppresses the HI/LO write.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_res,
    output logic        o_wr
);

    logic signed [63:0] w_sa;
    logic signed [63:0] w_sb;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic               w_zero;
    logic               w_ovf;

    assign w_sa   = {{32{i_a[31]}}, i_a};
    assign w_sb   = {{32{i_b[31]}}, i_b};
    assign w_zero = (i_b == 32'd0);
    assign w_ovf  = (i_a == 32'h8000_0000) &&
                    (i_b == 32'hFFFF_FFFF);

    // Guard keeps the divider away from the two undefined cases
    assign w_sq = (w_zero || w_ovf) ? 32'sd0 :
                  $signed(i_a) / $signed(i_b);
    assign w_sr = (w_zero || w_ovf) ? 32'sd0 :
                  $signed(i_a) % $signed(i_b);

    always_comb begin
        o_res = '0;
        o_wr  = 1'b1;
        case (i_op)
            MDU_MULT: begin
                o_res = w_sa * w_sb;
            end
            MDU_MULTU: begin
                o_res = {32'd0, i_a} * {32'd0, i_b};
            end
            MDU_DIV: begin
                if (w_zero) begin
                    o_wr = 1'b0;
                end else if (w_ovf) begin
                    o_res = {32'd0, 32'h8000_0000};
                end else begin
                    o_res = {w_sr, w_sq};
                end
            end
            MDU_DIVU: begin
                if (w_zero) begin
                    o_wr = 1'b0;
                end else begin
                    o_res = {i_a % i_b, i_a / i_b};
                end
            end
            default: begin
                o_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: HI/LO mult/div sequencer with fixed latency and D-stall.
// Ports: start/op/a/b/cancel from E, d_uses_md from D; busy/stall/hi/lo out.
// Optional MDU_PERF_CNT_EN adds stall_cnt (cycles with stall high).
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MDU_MULT_LAT,
    parameter int DIV_LAT  = MDU_DIV_LAT,
    parameter int CNT_W    = MDU_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef MDU_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;

    logic             w_issue;
    logic             w_md_go;
    logic [63:0]      w_res;
    logic             w_wr;

    assign w_issue = start & ~cancel;
    assign w_md_go = w_issue & is_md_op(op);

    assign stall = d_uses_md & (r_busy | w_md_go);
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

    mdu_arith u_arith (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_res (w_res),
        .o_wr  (w_wr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_md_go) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        // op[1] set selects div/divu
                        r_cnt   <= op[1] ?
                                   CNT_W'(DIV_LAT - 1) :
                                   CNT_W'(MULT_LAT - 1);
                    end else if (w_issue &&
                                 op == MDU_MTHI) begin
                        r_hi <= a;
                    end else if (w_issue &&
                                 op == MDU_MTLO) begin
                        r_lo <= a;
                    end
                end
                ST_RUN: begin
                    // start/cancel are ignored while running
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (w_wr) begin
                            r_hi <= w_res[63:32];
                            r_lo <= w_res[31:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MDU_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
